// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared processor types and constants (fetch FSM states, default reset PC, instruction width)
package instr_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} fetch_state_t;
  localparam int INSTR_W = 16;
  localparam int RESET_PC_DEF = 0;
endpackage

// File: rtl/instr_fetch_fetch_buf.sv
// fetch_buf: one-entry valid/data register; ports clk, rst, load (wins over flush), flush, din -> valid, data
module fetch_buf
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] din,
  output logic               valid,
  output logic [INSTR_W-1:0] data
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (flush) valid <= 1'b0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit (imem_req/addr/ack/rdata -> IR/ir_valid/pc, ir_take, br_en/br_addr redirect); INSTR_FETCH_PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IR,
  output logic               ir_valid,
  input  logic               ir_take,
  input  logic               br_en,
  input  logic [PC_W-1:0]    br_addr,
  output logic [PC_W-1:0]    pc
);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  fetch_state_t state;
  logic [PC_W-1:0] fetch_pc, ir_pc;
  logic discard, take, ack_ok, room, ir_load;
  logic [INSTR_W-1:0] ir_din;
  assign take   = ir_take & ir_valid & ~br_en;
  assign ack_ok = (state == WAIT) & imem_ack & ~discard & ~br_en;
`ifdef INSTR_FETCH_PREFETCH_EN
  logic pb_valid, pb_load;
  logic [INSTR_W-1:0] pb_data;
  logic [PC_W-1:0] pb_pc;
  assign room    = ~pb_valid | take;
  assign ir_load = take ? (pb_valid | ack_ok) : (ack_ok & ~ir_valid);
  assign ir_din  = (take & pb_valid) ? pb_data : imem_rdata;
  assign ir_pc   = (take & pb_valid) ? pb_pc : imem_addr;
  assign pb_load = ack_ok & ir_valid & (~take | pb_valid);
  fetch_buf u_pb (
    .clk(clk), .rst(rst), .load(pb_load), .flush(br_en | take),
    .din(imem_rdata), .valid(pb_valid), .data(pb_data)
  );
  always_ff @(posedge clk)
    if (rst) pb_pc <= RST_PC;
    else if (pb_load) pb_pc <= imem_addr;
`else
  assign room    = ~ir_valid | take;
  assign ir_load = ack_ok;
  assign ir_din  = imem_rdata;
  assign ir_pc   = imem_addr;
`endif
  fetch_buf u_ir (
    .clk(clk), .rst(rst), .load(ir_load), .flush(br_en | take),
    .din(ir_din), .valid(ir_valid), .data(IR)
  );
  // A redirect while a request is outstanding waits out the stale ack before refetching.
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RST_PC;
      pc        <= RST_PC;
      imem_req  <= 1'b0;
      imem_addr <= RST_PC;
      discard   <= 1'b0;
    end else begin
      if (ir_load) pc <= ir_pc;
      if (br_en) begin
        fetch_pc <= br_addr;
        if (state == REQ || (state == WAIT && !imem_ack)) begin
          state    <= WAIT;
          imem_req <= 1'b0;
          discard  <= 1'b1;
        end else begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= br_addr;
          discard   <= 1'b0;
        end
      end else
        case (state)
          IDLE, FULL:
            if (room) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
            end
          REQ: begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
          WAIT:
            if (imem_ack) begin
              state     <= discard ? REQ : FULL;
              imem_req  <= discard;
              imem_addr <= fetch_pc;
              discard   <= 1'b0;
              if (!discard) fetch_pc <= fetch_pc + 1'b1;
            end
          default: state <= IDLE;
        endcase
    end
endmodule
